// File: rtl/tx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_ctrl_if
// Brief    : Byte handshake between the frame controller and the UART TX.
// Revision : 1.0
// ============================================================================
interface tx_frame_ctrl_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (output tx_en, output tx_data, input tx_done);
    modport slave  (input tx_en, input tx_data, output tx_done);
endinterface
`default_nettype wire

// File: rtl/tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_ctrl
// Brief    : Periodic frame uploader (header, data bytes LSB-first, optional
//            checksum). Define TX_FRAME_CHECKSUM_EN to append the checksum byte.
// Revision : 1.0
// ============================================================================
module tx_frame_ctrl #(
    parameter int         N_BYTES  = 4,
    parameter int         PERIOD   = 5000000,
    parameter int         PERIOD_W = 25,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_BYTES-1:0] data_in_i,
    tx_frame_ctrl_if.master      tx,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 overrun_o
);

`ifdef TX_FRAME_CHECKSUM_EN
    localparam int C_LAST_IDX = N_BYTES + 1;
`else
    localparam int C_LAST_IDX = N_BYTES;
`endif
    localparam int C_IDX_W = $clog2(N_BYTES + 2);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_SEND = 2'd1;
    localparam logic [1:0] C_ST_GAP  = 2'd2;

    logic [1:0]           state_q,      state_d;
    logic [PERIOD_W-1:0]  cnt_q,        cnt_d;
    logic [C_IDX_W-1:0]   idx_q,        idx_d;
    logic [8*N_BYTES-1:0] shadow_q,     shadow_d;
    logic [7:0]           tx_data_q,    tx_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q,    overrun_d;

    logic                 w_tick;
    logic [7:0]           w_next_byte;

    assign w_tick = (cnt_q == PERIOD_W'(PERIOD - 1));

`ifdef TX_FRAME_CHECKSUM_EN
    logic [7:0] w_checksum;

    always_comb begin
        w_checksum = 8'h00;
        for (int k = 0; k < N_BYTES; k++) begin
            w_checksum = w_checksum + shadow_q[8*k +: 8];
        end
    end
`endif

    // idx_q already points at the byte to load when the GAP state is reached
    always_comb begin
        w_next_byte = HEADER;
        for (int k = 0; k < N_BYTES; k++) begin
            if (idx_q == C_IDX_W'(k + 1)) begin
                w_next_byte = shadow_q[8*k +: 8];
            end
        end
`ifdef TX_FRAME_CHECKSUM_EN
        if (idx_q == C_IDX_W'(C_LAST_IDX)) begin
            w_next_byte = w_checksum;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= C_ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            tx_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        tx_data_d    = tx_data_q;
        cnt_d        = w_tick ? '0 : cnt_q + 1'b1;
        frame_done_d = 1'b0;
        // A tick that lands on a running frame (even its last cycle) is dropped
        overrun_d    = w_tick && (state_q != C_ST_IDLE);

        case (state_q)
            C_ST_IDLE: begin
                if (w_tick) begin
                    shadow_d  = data_in_i;
                    tx_data_d = HEADER;
                    idx_d     = '0;
                    state_d   = C_ST_SEND;
                end
            end
            C_ST_SEND: begin
                if (tx.tx_done) begin
                    if (idx_q == C_IDX_W'(C_LAST_IDX)) begin
                        frame_done_d = 1'b1;
                        state_d      = C_ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = C_ST_GAP;
                    end
                end
            end
            C_ST_GAP: begin
                tx_data_d = w_next_byte;
                state_d   = C_ST_SEND;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx.tx_en     = (state_q == C_ST_SEND);
        tx.tx_data   = tx_data_q;
        busy_o       = (state_q != C_ST_IDLE);
        frame_done_o = frame_done_q;
        overrun_o    = overrun_q;
    end

endmodule
`default_nettype wire
